// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arbiter_if #(
    parameter int N  = 8,
    parameter int NB = (N > 1) ? $clog2(N) : 1
);
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [NB-1:0] gnt_idx;
    logic          gnt_vld;
    logic          timeout;

    modport master (output en, req, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot + binary grant, held until the owner drops req.
// ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced release with a one-cycle timeout pulse.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter_if.slave bus
);
    localparam int NB = (N > 1) ? $clog2(N) : 1;

    if (N < 2) begin : g_bad_n
        $error("rr_arbiter: N must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic {IDLE, GRANT} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [NB-1:0] idx_q, idx_d;
    logic [NB-1:0] last_q, last_d;
    logic          vld_q, vld_d;
    logic [NB:0]   pick;
    logic          grant_new;
    logic          owner_req;
    logic          expire;

    // First set bit after base, wrapping at N (not 2^NB); MSB of result = found.
    function automatic logic [NB:0] scan(input logic [N-1:0] r, input logic [NB-1:0] base);
        logic          found;
        logic [NB-1:0] win;
        int            j;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(base) + k;
            if (j >= N) j = j - N;
            if (!found && r[j]) begin
                found = 1'b1;
                win   = NB'(j);
            end
        end
        return {found, win};
    endfunction

    assign owner_req = bus.req[idx_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        vld_d     = vld_q;
        pick      = '0;
        grant_new = 1'b0;
        case (state_q)
            IDLE: begin
                pick      = scan(bus.req, last_q);
                grant_new = bus.en && pick[NB];
            end
            GRANT: begin
                if (!owner_req || expire) begin
                    // The outgoing owner is masked so a preempted requester waits a full round.
                    last_d    = idx_q;
                    pick      = scan(bus.req & ~gnt_q, idx_q);
                    grant_new = bus.en && pick[NB];
                    if (!grant_new) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_new) begin
            state_d = GRANT;
            idx_d   = pick[NB-1:0];
            gnt_d   = N'(1) << pick[NB-1:0];
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= NB'(N - 1);
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    assign expire = (state_q == GRANT) && owner_req && (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_new)              cnt_d = '0;
        else if (state_q == GRANT)  cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= expire;
        end
    end

    assign bus.timeout = to_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: an N=8 instance and an N=5 instance sharing clk/rst_n.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.N(8)) bus8 ();
    rr_arbiter_if #(.N(5)) bus5 ();

    rr_arbiter #(.N(8), .MAX_HOLD(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    rr_arbiter #(.N(5), .MAX_HOLD(4)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] g, input int idx, input logic v);
        chk({tag, ".gnt"}, 32'(bus8.gnt), 32'(g));
        chk({tag, ".idx"}, 32'(bus8.gnt_idx), 32'(idx));
        chk({tag, ".vld"}, 32'(bus8.gnt_vld), 32'(v));
    endtask

    task automatic chk5(input string tag, input logic [4:0] g, input int idx, input logic v);
        chk({tag, ".gnt"}, 32'(bus5.gnt), 32'(g));
        chk({tag, ".idx"}, 32'(bus5.gnt_idx), 32'(idx));
        chk({tag, ".vld"}, 32'(bus5.gnt_vld), 32'(v));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus8.req = 8'hFF;
        bus8.en  = 1'b1;
        bus5.req = 5'h1F;
        bus5.en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8("reset", 8'h00, 0, 1'b0);
            chk("reset.to", 32'(bus8.timeout), 32'd0);
        end
        rst_n    = 1'b1;
        bus8.req = 8'h00;
        bus5.req = 5'h00;
    endtask

    initial begin
        int exp_idx [10];
        int exp_to  [10];

        // Reset with everyone requesting
        do_reset();
        tick();
        chk8("idle_after_reset", 8'h00, 0, 1'b0);

        // Basic grant and handoff
        bus8.req = 8'h05;
        tick();
        chk8("basic.g0", 8'h01, 0, 1'b1);
        bus8.req = 8'h04;
        tick();
        chk8("basic.g2", 8'h04, 2, 1'b1);
        bus8.req = 8'h00;
        tick();
        chk8("basic.rel", 8'h00, 2, 1'b0);

        // Fairness from reset: 0..7,0,1 back to back
        do_reset();
        bus8.req = 8'hFF;
        tick();
        exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        for (int i = 0; i < 10; i++) begin
            chk8($sformatf("fair%0d", i), 8'h01 << exp_idx[i], exp_idx[i], 1'b1);
            bus8.req = 8'hFF & ~(8'h01 << exp_idx[i]);
            tick();
        end
        chk8("fair.next", 8'h04, 2, 1'b1);
        bus8.req = 8'h00;
        tick();
        chk8("fair.idle", 8'h00, 2, 1'b0);

        // Enable gating
        bus8.en  = 1'b0;
        bus8.req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk8($sformatf("en_off%0d", i), 8'h00, 2, 1'b0);
        end
        bus8.en = 1'b1;
        tick();
        chk8("en_on", 8'h10, 4, 1'b1);
        bus8.en  = 1'b0;
        bus8.req = 8'h11;
        tick();
        chk8("en_off_hold", 8'h10, 4, 1'b1);
        bus8.req = 8'h01;
        tick();
        chk8("en_off_release", 8'h00, 4, 1'b0);
        bus8.en  = 1'b1;
        bus8.req = 8'h00;
        tick();

        // Non-power-of-2 wrap on N=5
        bus5.req = 5'h10;
        tick();
        chk5("n5.g4", 5'h10, 4, 1'b1);
        bus5.req = 5'h00;
        tick();
        chk5("n5.idle", 5'h00, 4, 1'b0);
        bus5.req = 5'h11;
        tick();
        chk5("n5.wrap_idle", 5'h01, 0, 1'b1);
        bus5.req = 5'h18;
        tick();
        chk5("n5.g3", 5'h08, 3, 1'b1);
        bus5.req = 5'h18;
        tick();
        chk5("n5.hold3", 5'h08, 3, 1'b1);
        bus5.req = 5'h11;
        tick();
        chk5("n5.g4b", 5'h10, 4, 1'b1);
        bus5.req = 5'h01;
        tick();
        chk5("n5.wrap_rel", 5'h01, 0, 1'b1);
        bus5.req = 5'h08;
        tick();
        chk5("n5.pre_rst", 5'h08, 3, 1'b1);
        rst_n = 1'b0;
        tick();
        chk5("n5.rst", 5'h00, 0, 1'b0);
        rst_n    = 1'b1;
        bus5.req = 5'h18;
        tick();
        chk5("n5.post_rst", 5'h08, 3, 1'b1);
        bus5.req = 5'h00;

        // Timeout behaviour with req=0x03 held
        do_reset();
        bus8.req = 8'h03;
        tick();
`ifdef ARB_TIMEOUT_EN
        exp_idx = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        exp_to  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
`else
        exp_idx = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_to  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 10; i++) begin
            chk8($sformatf("hold%0d", i), 8'h01 << exp_idx[i], exp_idx[i], 1'b1);
            chk($sformatf("hold%0d.to", i), 32'(bus8.timeout), 32'(exp_to[i]));
            tick();
        end
        bus8.req = 8'h00;
        tick();
        chk("end.vld", 32'(bus8.gnt_vld), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
